// File: rtl/m_crc16_if.sv
// Byte-strobe / checksum bundle for the m_crc16 SD data CRC engine.
// master drives the byte stream, slave (the CRC engine) returns CRC and Valid.
interface m_crc16_if;
  logic        Enable;
  logic        GetData;
  logic [7:0]  Data;
  logic        Valid;
  logic [15:0] CRC;

  modport master (
    output Enable,
    output GetData,
    output Data,
    input  Valid,
    input  CRC
  );

  modport slave (
    input  Enable,
    input  GetData,
    input  Data,
    output Valid,
    output CRC
  );
endinterface

// File: rtl/m_crc16.sv
// SD/MMC data CRC16 (x^16+x^12+x^5+1, init 0, MSB first) over DATA_STRING bytes.
// Define M_CRC16_BYTE_PARALLEL_EN to fold a whole byte per capture instead of 1 bit/clock.
module m_crc16 #(
  parameter int unsigned DATA_STRING = 512
) (
  input logic       clk,
  input logic       Reset,
  m_crc16_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DATA_STRING + 1);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(DATA_STRING - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // ST_SHIFT is the busy window; ST_DONE is the Valid hold state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q,    state_d;
  logic [15:0]      crc_q,      crc_d;
  logic [7:0]       sh_q,       sh_d;
  logic [2:0]       bit_cnt_q,  bit_cnt_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;

  function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

`ifdef M_CRC16_BYTE_PARALLEL_EN
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int unsigned i = 0; i < 8; i++) begin
      r = crc_bit(r, d[3'(7 - i)]);
    end
    return r;
  endfunction
`endif

  always_comb begin
    state_d    = state_q;
    crc_d      = crc_q;
    sh_d       = sh_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;

    if (!bus.Enable) begin
      state_d    = ST_IDLE;
      crc_d      = '0;
      sh_d       = '0;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.GetData) begin
`ifdef M_CRC16_BYTE_PARALLEL_EN
            crc_d      = crc_byte(crc_q, bus.Data);
            byte_cnt_d = byte_cnt_q + CNT_ONE;
            if (byte_cnt_q == LAST_BYTE) state_d = ST_DONE;
`else
            sh_d      = bus.Data;
            bit_cnt_d = '0;
            state_d   = ST_SHIFT;
`endif
          end
        end
        ST_SHIFT: begin
          crc_d     = crc_bit(crc_q, sh_q[7]);
          sh_d      = {sh_q[6:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_cnt_d = byte_cnt_q + CNT_ONE;
            state_d    = (byte_cnt_q == LAST_BYTE) ? ST_DONE : ST_IDLE;
          end
        end
        ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      crc_q      <= '0;
      sh_q       <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      sh_q       <= sh_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  assign bus.CRC   = crc_q;
  assign bus.Valid = (state_q == ST_DONE);

endmodule

// File: tb/tb_m_crc16.sv
// Scoreboarded bench for m_crc16: a 512-byte instance and a 9-byte instance.
module tb_m_crc16;

`ifdef M_CRC16_BYTE_PARALLEL_EN
  localparam int GAP     = 1;
  localparam int GAP_MAX = 4;
`else
  localparam int GAP     = 9;
  localparam int GAP_MAX = 13;
`endif

  logic clk = 1'b0;
  logic Reset;
  int   test_cnt = 0;
  int   fail_cnt = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  m_crc16_if bus_a ();
  m_crc16_if bus_b ();

  m_crc16 #(.DATA_STRING(512)) u_dut_a (.clk(clk), .Reset(Reset), .bus(bus_a));
  m_crc16 #(.DATA_STRING(9))   u_dut_b (.clk(clk), .Reset(Reset), .bus(bus_b));

  // Byte-at-a-time formulation, independent of the DUT's bit-serial form.
  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  task automatic set_bus(input bit sel_b, input logic g, input logic [7:0] d);
    if (sel_b) begin bus_b.GetData = g; bus_b.Data = d; end
    else       begin bus_a.GetData = g; bus_a.Data = d; end
  endtask

  task automatic send_byte(input bit sel_b, input logic [7:0] d, input int gap, input bit extra);
    set_bus(sel_b, 1'b1, d);
    @(negedge clk);
    set_bus(sel_b, 1'b0, d);
    if (extra && gap >= 4) begin
      @(negedge clk);
      set_bus(sel_b, 1'b1, 8'hA5);
      @(negedge clk);
      set_bus(sel_b, 1'b0, 8'hA5);
      repeat (gap - 3) @(negedge clk);
    end else begin
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  // Bounded wait for Valid, then pop the scoreboard and compare CRC.
  task automatic check_done(input bit sel_b, input string name);
    logic [15:0] exp_crc;
    logic [15:0] got;
    logic        v;
    int          waited;
    waited = 0;
    v = sel_b ? bus_b.Valid : bus_a.Valid;
    while (!v && waited < 20) begin
      @(negedge clk);
      waited++;
      v = sel_b ? bus_b.Valid : bus_a.Valid;
    end
    test_cnt++;
    if (v !== 1'b1 || waited != 0) begin
      fail_cnt++;
      $display("FAIL %s_valid: Valid=%b after %0d extra cycles, required 1 after 0", name, v, waited);
    end
    exp_crc = exp_q.pop_front();
    got = sel_b ? bus_b.CRC : bus_a.CRC;
    test_cnt++;
    if (got !== exp_crc) begin
      fail_cnt++;
      $display("FAIL %s_crc: got %h, required %h", name, got, exp_crc);
    end
  endtask

  task automatic enable_pulse_low(input bit sel_b, input string name);
    logic [15:0] got;
    logic        v;
    if (sel_b) bus_b.Enable = 1'b0; else bus_a.Enable = 1'b0;
    set_bus(sel_b, 1'b1, 8'h5A);  // clear must win over a simultaneous strobe
    @(negedge clk);
    set_bus(sel_b, 1'b0, 8'h5A);
    got = sel_b ? bus_b.CRC : bus_a.CRC;
    v   = sel_b ? bus_b.Valid : bus_a.Valid;
    test_cnt++;
    if (got !== 16'h0000 || v !== 1'b0) begin
      fail_cnt++;
      $display("FAIL %s_clear: CRC=%h Valid=%b, required 0000/0", name, got, v);
    end
    if (sel_b) bus_b.Enable = 1'b1; else bus_a.Enable = 1'b1;
  endtask

  task automatic run_block_a(input logic [7:0] val, input int extra_idx, input string name);
    logic [15:0] m;
    m = 16'h0000;
    for (int i = 0; i < 512; i++) begin
      if (i == 511) begin
        test_cnt++;
        if (bus_a.Valid !== 1'b0) begin
          fail_cnt++;
          $display("FAIL %s_early: Valid=%b before last byte, required 0", name, bus_a.Valid);
        end
      end
      m = crc_model(m, val);
`ifdef M_CRC16_BYTE_PARALLEL_EN
      send_byte(1'b0, val, GAP, 1'b0);
`else
      send_byte(1'b0, val, GAP, i == extra_idx);
`endif
    end
    exp_q.push_back((val == 8'hFF) ? 16'h7FA1 : m);
    check_done(1'b0, name);
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    bus_a.Enable = 1'b1; bus_b.Enable = 1'b1;
    set_bus(1'b0, 1'b1, 8'hFF);
    set_bus(1'b1, 1'b1, 8'hFF);
    repeat (2) @(negedge clk);
    test_cnt++;
    if (bus_a.CRC !== 16'h0000 || bus_a.Valid !== 1'b0) begin
      fail_cnt++;
      $display("FAIL reset_a: CRC=%h Valid=%b, required 0000/0", bus_a.CRC, bus_a.Valid);
    end
    test_cnt++;
    if (bus_b.CRC !== 16'h0000 || bus_b.Valid !== 1'b0) begin
      fail_cnt++;
      $display("FAIL reset_b: CRC=%h Valid=%b, required 0000/0", bus_b.CRC, bus_b.Valid);
    end
    set_bus(1'b0, 1'b0, 8'h00);
    set_bus(1'b1, 1'b0, 8'h00);
    Reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ones_block;
    run_block_a(8'hFF, -1, "ones");
    send_byte(1'b0, 8'h00, GAP + 1, 1'b0);
    test_cnt++;
    if (bus_a.CRC !== 16'h7FA1 || bus_a.Valid !== 1'b1) begin
      fail_cnt++;
      $display("FAIL post_valid_strobe: CRC=%h Valid=%b, required 7fa1/1", bus_a.CRC, bus_a.Valid);
    end
  endtask

  task automatic test_enable_drop;
    enable_pulse_low(1'b0, "restart");
    for (int i = 0; i < 100; i++) send_byte(1'b0, 8'hFF, GAP, 1'b0);
    enable_pulse_low(1'b0, "abort");
    run_block_a(8'hFF, -1, "after_abort");
  endtask

  task automatic test_zero_block;
    enable_pulse_low(1'b0, "zero_start");
    run_block_a(8'h00, -1, "zeros");
  endtask

  task automatic test_ignored_strobe;
    enable_pulse_low(1'b0, "ignore_start");
    run_block_a(8'hFF, 37, "ignored_strobe");
  endtask

  task automatic test_reset_mid_byte;
    enable_pulse_low(1'b0, "midrst_start");
    for (int i = 0; i < 3; i++) send_byte(1'b0, 8'hFF, GAP, 1'b0);
    set_bus(1'b0, 1'b1, 8'hC3);
    @(negedge clk);
    set_bus(1'b0, 1'b0, 8'hC3);
    @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    test_cnt++;
    if (bus_a.CRC !== 16'h0000 || bus_a.Valid !== 1'b0) begin
      fail_cnt++;
      $display("FAIL mid_reset: CRC=%h Valid=%b, required 0000/0", bus_a.CRC, bus_a.Valid);
    end
    // First byte strobed immediately: only accepted if reset left the engine idle.
    run_block_a(8'hFF, -1, "after_reset");
  endtask

  task automatic test_check_string;
    enable_pulse_low(1'b1, "str_start");
    for (int i = 0; i < 9; i++) begin
      logic [7:0] c;
      c = 8'h31 + 8'(i);
      send_byte(1'b1, c, GAP, 1'b0);
    end
    exp_q.push_back(16'h31C3);
    check_done(1'b1, "check_string");
  endtask

  task automatic test_back_to_back;
    logic [15:0] m;
    logic [7:0]  d;
    int          g;
    for (int blk = 0; blk < 2; blk++) begin
      enable_pulse_low(1'b1, "rand_start");
      m = 16'h0000;
      for (int i = 0; i < 9; i++) begin
        d = 8'($urandom_range(0, 255));
        g = (blk == 0) ? GAP : int'($urandom_range(GAP, GAP_MAX));
        m = crc_model(m, d);
        send_byte(1'b1, d, g, 1'b0);
        if (i < 8) begin
          test_cnt++;
          if (bus_b.CRC !== m) begin
            fail_cnt++;
            $display("FAIL running_crc: byte %0d got %h, required %h", i, bus_b.CRC, m);
          end
        end
      end
      exp_q.push_back(m);
      check_done(1'b1, "random_block");
    end
  endtask

  initial begin
    Reset = 1'b1;
    bus_a.Enable = 1'b0; bus_a.GetData = 1'b0; bus_a.Data = 8'h00;
    bus_b.Enable = 1'b0; bus_b.GetData = 1'b0; bus_b.Data = 8'h00;
    @(negedge clk);
    test_reset();
    test_ones_block();
    test_enable_drop();
    test_zero_block();
    test_ignored_strobe();
    test_reset_mid_byte();
    test_check_string();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
